bch_decoder_ctrl: RTL and testbench



---
 rtl/bch_decoder_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_bch_decoder_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bch_decoder_ctrl.sv
// BCH(15,7) double-error-correcting decoder controller over GF(2^4), x^4+x+1.
// Serial syndromes, combinational key-equation block, serial Chien search.

package bch_gf_pkg;

    typedef enum logic [2:0] {IDLE, SYND, KEY, CHIEN, DONE} state_e;

    localparam logic [3:0] ALPHA   = 4'h2;  // alpha
    localparam logic [3:0] ALPHA3  = 4'h8;  // alpha^3
    localparam logic [3:0] ALPHA13 = 4'hD;  // alpha^13 = alpha^-2
    localparam logic [3:0] ALPHA14 = 4'h9;  // alpha^14 = alpha^-1

    // Shift-and-add multiply; with a constant operand it folds to an XOR network.
    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] t;
        p = '0;
        t = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[2:0], 1'b0} ^ (t[3] ? 4'b0011 : 4'b0000);
        end
        return p;
    endfunction

    // a^-1 = a^14 = a^8 * a^4 * a^2; maps 0 to 0.
    function automatic logic [3:0] gf_inv(input logic [3:0] a);
        logic [3:0] a2;
        logic [3:0] a4;
        logic [3:0] a8;
        a2 = gf_mul(a, a);
        a4 = gf_mul(a2, a2);
        a8 = gf_mul(a4, a4);
        return gf_mul(gf_mul(a8, a4), a2);
    endfunction

endpackage

// Peterson solution for t = 2: lambda1 = S1, lambda2 = (S3 + S1^3) / S1.
// S1 = 0 with S3 != 0 means three or more errors; lambda = 1 + S3*x^2 then has
// exactly one root against an expected degree of 2, so the word is flagged.
module bch_cbm_block
    import bch_gf_pkg::*;
(
    input  logic [3:0] S1,
    input  logic [3:0] S2,
    input  logic [3:0] S3,
    output logic [3:0] lambda1,
    output logic [3:0] lambda2
);
    // Solve the key equation directly from the syndromes.
    always_comb begin
        if (S1 != 4'h0) begin
            lambda1 = S1;
            lambda2 = gf_mul(S3 ^ gf_mul(S1, S2), gf_inv(S1));
        end else begin
            lambda1 = 4'h0;
            lambda2 = S3;
        end
    end
endmodule

module bch_decoder_ctrl
    import bch_gf_pkg::*;
#(
    parameter int N = 15,
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_word,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_word,
    output logic [1:0]   out_nerr,
    output logic         out_uncorr
);
    state_e       state_q, state_d;
    logic [N-1:0] rbuf_q, rbuf_d;
    logic [N-1:0] mask_q, mask_d;
    logic [M-1:0] s1_q, s1_d, s3_q, s3_d;
    logic [M-1:0] t1_q, t1_d, t2_q, t2_d;
    logic [3:0]   cnt_q, cnt_d;          // SYND bit index, then CHIEN position
    logic [1:0]   deg_q, deg_d;
    logic [1:0]   nroot_q, nroot_d;
    logic         out_valid_q, out_valid_d;
    logic [N-1:0] out_word_q, out_word_d;
    logic [1:0]   out_nerr_q, out_nerr_d;
    logic         out_uncorr_q, out_uncorr_d;

    logic [M-1:0] lambda1, lambda2;
    logic [M-1:0] chien_eval;

    bch_cbm_block u_cbm (
        .S1      (s1_q),
        .S2      (gf_mul(s1_q, s1_q)),
        .S3      (s3_q),
        .lambda1 (lambda1),
        .lambda2 (lambda2)
    );

    // Lambda(alpha^-i) for the current Chien position.
    assign chien_eval = 4'h1 ^ t1_q ^ t2_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = SYND;
            SYND:    if (cnt_q == 4'd0) state_d = KEY;
            KEY:     state_d = CHIEN;
            CHIEN:   if (cnt_q == 4'd14) state_d = DONE;
            DONE:    if (out_valid_q && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        in_ready = (state_q == IDLE);
    end

    // Datapath next values for each state.
    always_comb begin
        rbuf_d       = rbuf_q;
        mask_d       = mask_q;
        s1_d         = s1_q;
        s3_d         = s3_q;
        t1_d         = t1_q;
        t2_d         = t2_q;
        cnt_d        = cnt_q;
        deg_d        = deg_q;
        nroot_d      = nroot_q;
        out_valid_d  = out_valid_q;
        out_word_d   = out_word_q;
        out_nerr_d   = out_nerr_q;
        out_uncorr_d = out_uncorr_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    rbuf_d = in_word;
                    s1_d   = '0;
                    s3_d   = '0;
                    cnt_d  = 4'd14;
                end
            end
            SYND: begin
                // Horner evaluation of r(alpha) and r(alpha^3), highest bit first.
                s1_d  = gf_mul(s1_q, ALPHA)  ^ {3'b000, rbuf_q[cnt_q]};
                s3_d  = gf_mul(s3_q, ALPHA3) ^ {3'b000, rbuf_q[cnt_q]};
                cnt_d = cnt_q - 4'd1;
            end
            KEY: begin
                t1_d    = lambda1;
                t2_d    = lambda2;
                deg_d   = (lambda2 != 4'h0) ? 2'd2 : ((lambda1 != 4'h0) ? 2'd1 : 2'd0);
                mask_d  = '0;
                nroot_d = 2'd0;
                cnt_d   = 4'd0;
            end
            CHIEN: begin
                if (chien_eval == 4'h0) begin
                    mask_d[cnt_q] = 1'b1;
                    if (nroot_q != 2'd3) nroot_d = nroot_q + 2'd1;
                end
                t1_d  = gf_mul(t1_q, ALPHA14);
                t2_d  = gf_mul(t2_q, ALPHA13);
                cnt_d = cnt_q + 4'd1;
            end
            DONE: begin
                if (!out_valid_q) begin
                    // First DONE cycle: mask and root count are final, publish.
                    out_valid_d = 1'b1;
                    if (nroot_q == deg_q) begin
                        out_word_d   = rbuf_q ^ mask_q;
                        out_nerr_d   = nroot_q;
                        out_uncorr_d = 1'b0;
                    end else begin
                        out_word_d   = rbuf_q;
                        out_nerr_d   = 2'd0;
                        out_uncorr_d = 1'b1;
                    end
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rbuf_q       <= '0;
            mask_q       <= '0;
            s1_q         <= '0;
            s3_q         <= '0;
            t1_q         <= '0;
            t2_q         <= '0;
            cnt_q        <= '0;
            deg_q        <= '0;
            nroot_q      <= '0;
            out_valid_q  <= 1'b0;
            out_word_q   <= '0;
            out_nerr_q   <= '0;
            out_uncorr_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its peers.
            rbuf_q       <= rbuf_d;
            mask_q       <= mask_d;
            s1_q         <= s1_d;
            s3_q         <= s3_d;
            t1_q         <= t1_d;
            t2_q         <= t2_d;
            cnt_q        <= cnt_d;
            deg_q        <= deg_d;
            nroot_q      <= nroot_d;
            out_valid_q  <= out_valid_d;
            out_word_q   <= out_word_d;
            out_nerr_q   <= out_nerr_d;
            out_uncorr_q <= out_uncorr_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_word   = out_word_q;
    assign out_nerr   = out_nerr_q;
    assign out_uncorr = out_uncorr_q;

endmodule

// File: tb/tb_bch_decoder_ctrl.sv
// Directed bench for bch_decoder_ctrl with an expected-result scoreboard queue.
module tb_bch_decoder_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [14:0] in_word = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [14:0] out_word;
    logic [1:0]  out_nerr;
    logic        out_uncorr;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t_acc = 0;
    int t_prev = 0;
    int lat = 0;

    typedef struct {
        logic [14:0] word;
        logic [1:0]  nerr;
        logic        unc;
    } exp_t;

    exp_t sb[$];

    bch_decoder_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_word    (in_word),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_word   (out_word),
        .out_nerr   (out_nerr),
        .out_uncorr (out_uncorr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Handshake one word in and push its expected result.
    task automatic accept(input logic [14:0] w, input logic [14:0] ew,
                          input logic [1:0] en, input logic eu);
        exp_t e;
        e.word = ew;
        e.nerr = en;
        e.unc  = eu;
        check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        sb.push_back(e);
        in_valid = 1'b1;
        in_word  = w;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_word  = 15'($urandom);
        t_acc    = cyc;
    endtask

    // Bounded wait for out_valid; lat is the edge count after the accept edge.
    task automatic wait_result();
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 40);
        check("latency", lat, 32);
    endtask

    task automatic compare_result();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("out_valid", {31'd0, out_valid}, 32'd1);
            check("out_word", {17'd0, out_word}, {17'd0, e.word});
            check("out_nerr", {30'd0, out_nerr}, {30'd0, e.nerr});
            check("out_uncorr", {31'd0, out_uncorr}, {31'd0, e.unc});
        end
    endtask

    // Full transaction with out_ready held high.
    task automatic transact(input logic [14:0] w, input logic [14:0] ew,
                            input logic [1:0] en, input logic eu);
        accept(w, ew, en, eu);
        wait_result();
        compare_result();
        @(posedge clk);
        #1;
        check("out_valid_after_hs", {31'd0, out_valid}, 32'd0);
        check("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        // Reset state.
        #2;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_word", {17'd0, out_word}, 32'd0);
        check("rst_out_nerr", {30'd0, out_nerr}, 32'd0);
        check("rst_out_uncorr", {31'd0, out_uncorr}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Codeword, single, double errors, uncorrectable (S1 = 0, S3 != 0), zero word.
        transact(15'h01D1, 15'h01D1, 2'd0, 1'b0);
        transact(15'h0001, 15'h0000, 2'd1, 1'b0);
        transact(15'h0408, 15'h0000, 2'd2, 1'b0);
        transact(15'h4000 ^ 15'h01D1 ^ 15'h0002, 15'h01D1, 2'd2, 1'b0);
        transact(15'h0421, 15'h0421, 2'd0, 1'b1);
        transact(15'h0000, 15'h0000, 2'd0, 1'b0);

        // Backpressure: result held 10 cycles, stray in_valid ignored.
        out_ready = 1'b0;
        accept(15'h0408, 15'h0000, 2'd2, 1'b0);
        wait_result();
        for (int k = 0; k < 10; k++) begin
            if (k == 4) begin
                in_valid = 1'b1;
                in_word  = 15'h0001;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_out_word", {17'd0, out_word}, 32'd0);
            check("bp_out_nerr", {30'd0, out_nerr}, 32'd2);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        compare_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("bp_no_ghost_result", {31'd0, out_valid}, 32'd0);
            check("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
        end

        // Back-to-back stream, 34 edges between accepts.
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: transact(15'h01D1, 15'h01D1, 2'd0, 1'b0);
                1: transact(15'h0001, 15'h0000, 2'd1, 1'b0);
                2: transact(15'h0408, 15'h0000, 2'd2, 1'b0);
                default: transact(15'h41D3, 15'h01D1, 2'd2, 1'b0);
            endcase
            if (k > 0) check("b2b_spacing", t_acc - t_prev, 34);
            t_prev = t_acc;
        end

        // Reset mid-CHIEN discards the in-flight word.
        in_valid = 1'b1;
        in_word  = 15'h0408;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (19) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_out_word", {17'd0, out_word}, 32'd0);
        check("midrst_out_nerr", {30'd0, out_nerr}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        transact(15'h0001, 15'h0000, 2'd1, 1'b0);

        check("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
